// File: rtl/proc_pkg.sv
// Shared types for the basic processor fetch path: FSM state encoding and PC type.
package proc_pkg;

    localparam int PC_W_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

    typedef logic [PC_W_DEFAULT-1:0] pc_t;

endpackage

// File: rtl/ras_stack.sv
// Return-address LIFO; push/pop take effect on the next edge, top is combinational.
// Push when full and pop when empty are dropped; the caller flags the error.
module ras_stack
    import proc_pkg::*;
#(
    parameter int W     = PC_W_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_clear,
    input  logic [W-1:0] i_dat,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_top
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_cnt;
    logic [PTR_W-1:0] w_top_ptr;

    assign o_full    = (r_cnt == PTR_W'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign w_top_ptr = r_cnt - PTR_W'(1);
    assign o_top     = r_mem[w_top_ptr[IDX_W-1:0]];

    always_ff @(posedge Clk) begin
        if (Reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_push && !o_full) begin
            r_cnt <= r_cnt + PTR_W'(1);
        end else if (i_pop && !o_empty) begin
            r_cnt <= r_cnt - PTR_W'(1);
        end
    end

    // Storage needs no reset: entries are only read below the count.
    always_ff @(posedge Clk) begin
        if (i_push && !o_full && !i_clear && !Reset) begin
            r_mem[r_cnt[IDX_W-1:0]] <= i_dat;
        end
    end

endmodule

// File: rtl/inst_fetch_seq.sv
// PC / fetch sequencer: IDLE->ARMED->RUN->DONE, branches, call/return; all outputs registered.
// Optional return-address stack enabled by INST_FETCH_RAS_EN; otherwise Call==BranchAbs, Ret==increment.
module inst_fetch_seq
    import proc_pkg::*;
#(
    parameter int                    PC_W       = PC_W_DEFAULT,
    parameter int                    NUM_PROGS  = 3,
    parameter logic [NUM_PROGS*PC_W-1:0] PROG_BASES = '0,
    parameter int                    RAS_DEPTH  = 4,
    localparam int                   SEL_W      = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [SEL_W-1:0] ProgSel,
    input  logic             Stall,
    input  logic             Halt,
    input  logic             BranchAbs,
    input  logic             BranchRelEn,
    input  logic             ALU_flag,
    input  logic             Call,
    input  logic             Ret,
    input  logic [PC_W-1:0]  Target,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Running,
    output logic             Done,
    output logic             StackErr
);

    fetch_state_t    r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_running;
    logic            r_done;
    logic [PC_W-1:0] w_base;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_pc_rel;

    // Out-of-range selections fall back to program 0.
    always_comb begin
        w_base = PROG_BASES[0 +: PC_W];
        for (int i = 1; i < NUM_PROGS; i++) begin
            if (ProgSel == SEL_W'(i)) begin
                w_base = PROG_BASES[i*PC_W +: PC_W];
            end
        end
    end

    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_pc_rel = r_pc + Target;

`ifdef INST_FETCH_RAS_EN
    logic            r_stack_err;
    logic            w_ras_full;
    logic            w_ras_empty;
    logic [PC_W-1:0] w_ras_top;
    logic            w_run_act;
    logic            w_push;
    logic            w_pop;
    logic            w_clear;

    assign w_run_act = (r_state == RUN) && !Start && !Stall && !Halt;
    assign w_pop     = w_run_act && Ret && !w_ras_empty;
    assign w_push    = w_run_act && !Ret && Call && !w_ras_full;
    assign w_clear   = (r_state == ARMED);

    ras_stack #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .i_dat   (w_pc_inc),
        .o_full  (w_ras_full),
        .o_empty (w_ras_empty),
        .o_top   (w_ras_top)
    );

    assign StackErr = r_stack_err;
`else
    assign StackErr = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_pc      <= PROG_BASES[0 +: PC_W];
            r_running <= 1'b0;
            r_done    <= 1'b0;
`ifdef INST_FETCH_RAS_EN
            r_stack_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (Start) r_state <= ARMED;
                end
                ARMED: begin
                    r_pc <= w_base;
`ifdef INST_FETCH_RAS_EN
                    r_stack_err <= 1'b0;
`endif
                    if (!Start) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                RUN: begin
                    if (Start) begin
                        r_state   <= ARMED;
                        r_running <= 1'b0;
                    end else if (Stall) begin
                        r_pc <= r_pc;
                    end else if (Halt) begin
                        r_state   <= DONE;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
`ifdef INST_FETCH_RAS_EN
                    end else if (Ret) begin
                        if (!w_ras_empty) begin
                            r_pc <= w_ras_top;
                        end else begin
                            r_pc        <= w_pc_inc;
                            r_stack_err <= 1'b1;
                        end
                    end else if (Call) begin
                        r_pc <= Target;
                        if (w_ras_full) r_stack_err <= 1'b1;
`else
                    end else if (Ret) begin
                        r_pc <= w_pc_inc;
                    end else if (Call) begin
                        r_pc <= Target;
`endif
                    end else if (BranchAbs) begin
                        r_pc <= Target;
                    end else if (BranchRelEn && ALU_flag) begin
                        r_pc <= w_pc_rel;
                    end else begin
                        r_pc <= w_pc_inc;
                    end
                end
                DONE: begin
                    if (Start) begin
                        r_state <= ARMED;
                        r_done  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ProgCtr = r_pc;
    assign Running = r_running;
    assign Done    = r_done;

endmodule

// File: tb/tb_inst_fetch_seq.sv
// Directed bench for inst_fetch_seq with a behavioural reference model feeding a scoreboard queue.
module tb_inst_fetch_seq;

    localparam int PC_W = 10;
    localparam logic [3*PC_W-1:0] BASES = {10'd0, 10'd100, 10'd200};

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [1:0]      sel = 2'd0;
    logic            stall = 1'b0, halt = 1'b0, babs = 1'b0, brel = 1'b0;
    logic            flag = 1'b0, call = 1'b0, ret = 1'b0;
    logic [PC_W-1:0] target = '0;
    logic [PC_W-1:0] pc;
    logic            running, done, serr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic            run;
        logic            done;
        logic            err;
        string           tag;
    } exp_t;
    exp_t sb[$];

    // Reference model state
    int              m_state = 0;   // 0 IDLE, 1 ARMED, 2 RUN, 3 DONE
    logic [PC_W-1:0] m_pc = '0;
    logic [PC_W-1:0] m_stk[$];
    logic            m_err = 1'b0;

    inst_fetch_seq #(
        .PC_W       (PC_W),
        .NUM_PROGS  (3),
        .PROG_BASES (BASES),
        .RAS_DEPTH  (4)
    ) dut (
        .Clk         (clk),
        .Reset       (rst),
        .Start       (start),
        .ProgSel     (sel),
        .Stall       (stall),
        .Halt        (halt),
        .BranchAbs   (babs),
        .BranchRelEn (brel),
        .ALU_flag    (flag),
        .Call        (call),
        .Ret         (ret),
        .Target      (target),
        .ProgCtr     (pc),
        .Running     (running),
        .Done        (done),
        .StackErr    (serr)
    );

    always #5 clk = ~clk;

    function automatic logic [PC_W-1:0] base_of(input logic [1:0] s);
        case (s)
            2'd1:    return 10'd100;
            2'd2:    return 10'd0;
            default: return 10'd200;
        endcase
    endfunction

    task automatic model_step();
        if (rst) begin
            m_state = 0; m_pc = 10'd200; m_stk.delete(); m_err = 1'b0;
        end else begin
            case (m_state)
                0: if (start) m_state = 1;
                1: begin
                    m_pc = base_of(sel); m_stk.delete(); m_err = 1'b0;
                    if (!start) m_state = 2;
                end
                2: begin
                    if (start) m_state = 1;
                    else if (stall) m_pc = m_pc;
                    else if (halt) m_state = 3;
                    else if (ret) begin
`ifdef INST_FETCH_RAS_EN
                        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                        else begin m_err = 1'b1; m_pc = m_pc + 10'd1; end
`else
                        m_pc = m_pc + 10'd1;
`endif
                    end else if (call) begin
`ifdef INST_FETCH_RAS_EN
                        if (m_stk.size() < 4) m_stk.push_back(m_pc + 10'd1);
                        else m_err = 1'b1;
`endif
                        m_pc = target;
                    end else if (babs) m_pc = target;
                    else if (brel && flag) m_pc = m_pc + target;
                    else m_pc = m_pc + 10'd1;
                end
                default: if (start) m_state = 1;
            endcase
        end
    endtask

    task automatic chk(input string tag, input int got, input int want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    // Drive current inputs for one edge; model predicts, scoreboard compares after the edge.
    task automatic step(input string tag);
        exp_t e;
        model_step();
        e.pc = m_pc; e.run = (m_state == 2); e.done = (m_state == 3); e.err = m_err; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        total++;
        assert (pc === e.pc) else begin
            bad++; $error("FAIL %s.pc got=%0d want=%0d", e.tag, pc, e.pc);
        end
        total++;
        assert (running === e.run) else begin
            bad++; $error("FAIL %s.running got=%0b want=%0b", e.tag, running, e.run);
        end
        total++;
        assert (done === e.done) else begin
            bad++; $error("FAIL %s.done got=%0b want=%0b", e.tag, done, e.done);
        end
        total++;
        assert (serr === e.err) else begin
            bad++; $error("FAIL %s.stackerr got=%0b want=%0b", e.tag, serr, e.err);
        end
    endtask

    task automatic ctl(input logic s_stall, input logic s_halt, input logic s_babs,
                       input logic s_brel, input logic s_flag, input logic s_call,
                       input logic s_ret, input logic [PC_W-1:0] s_tgt);
        stall = s_stall; halt = s_halt; babs = s_babs; brel = s_brel;
        flag = s_flag; call = s_call; ret = s_ret; target = s_tgt;
    endtask

    initial begin
        // Reset
        rst = 1'b1; ctl(0,0,0,0,0,0,0,0);
        step("reset0"); step("reset1");
        chk("reset_pc", pc, 200); chk("reset_run", running, 0);
        rst = 1'b0;
        step("idle");

        // Start program 1 for three cycles, then release
        start = 1'b1; sel = 2'd1;
        step("arm0"); step("arm1"); step("arm2");
        start = 1'b0;
        step("run_first"); chk("run_first_pc", pc, 100); chk("run_first_run", running, 1);
        step("inc1");      chk("inc1_pc", pc, 101);
        step("inc2");      chk("inc2_pc", pc, 102);

        // Relative branches
        ctl(0,0,1,0,0,0,0,10'd50);  step("babs50");
        ctl(0,0,0,1,1,0,0,10'h3FE); step("rel_taken");  chk("rel_taken_pc", pc, 48);
        ctl(0,0,1,0,0,0,0,10'd50);  step("babs50b");
        ctl(0,0,0,1,0,0,0,10'h3FE); step("rel_not");    chk("rel_not_pc", pc, 51);

        // Wrap and absolute branch
        ctl(0,0,1,0,0,0,0,10'd1023); step("babs1023");
        ctl(0,0,0,0,0,0,0,0);        step("wrap");      chk("wrap_pc", pc, 0);
        ctl(0,0,1,0,0,0,0,10'd5);    step("babs5");     chk("babs5_pc", pc, 5);
        ctl(1,0,0,0,0,0,0,0);        step("stall_only"); chk("stall_pc", pc, 5);

        // Call / return
        ctl(0,0,1,0,0,0,0,10'd20);   step("babs20");
        ctl(0,0,0,0,0,1,0,10'd300);  step("call300");   chk("call300_pc", pc, 300);
        ctl(0,0,0,0,0,0,1,0);        step("ret1");
`ifdef INST_FETCH_RAS_EN
        chk("ret1_pc", pc, 21);
`else
        chk("ret1_pc", pc, 301);
`endif
        for (int i = 0; i < 5; i++) begin
            ctl(0,0,0,0,0,1,0,PC_W'(400 + 10*i)); step($sformatf("nest%0d", i));
        end
        chk("nest5_pc", pc, 440);
`ifdef INST_FETCH_RAS_EN
        chk("nest5_err", serr, 1);
`else
        chk("nest5_err", serr, 0);
`endif
        for (int i = 0; i < 5; i++) begin
            ctl(0,0,0,0,0,0,1,0); step($sformatf("unwind%0d", i));
        end
`ifdef INST_FETCH_RAS_EN
        chk("ret_empty_pc", pc, 23); chk("ret_empty_err", serr, 1);
`else
        chk("ret_empty_pc", pc, 445);
`endif

        // Stall beats Halt, then Halt freezes
        ctl(1,1,0,0,0,0,0,0);        step("stall_halt"); chk("stall_halt_run", running, 1);
        ctl(0,1,0,0,0,0,0,0);        step("halt");       chk("halt_done", done, 1);
        ctl(0,0,1,0,0,1,1,10'd77);   step("done_ignore");
        ctl(0,0,0,0,0,0,0,0);        step("done_hold");

        // Restart program 2 from DONE
        start = 1'b1; sel = 2'd2;
        step("rearm0"); step("rearm1"); chk("rearm_err", serr, 0);
        start = 1'b0;
        step("run2"); step("run2_inc");
        ctl(0,0,0,0,0,1,0,10'd600);  step("call600");
        ctl(0,0,0,0,0,1,0,10'd700);  step("call700");

        // Abort mid-run via Start, then reset mid-run
        ctl(0,0,0,0,0,0,0,0);
        start = 1'b1; sel = 2'd1; step("abort");
        start = 1'b0; step("abort_run"); chk("abort_pc", pc, 100);
        ctl(0,0,0,0,0,1,0,10'd650);  step("call650");
        rst = 1'b1; ctl(0,0,0,0,0,0,0,0);
        step("mid_reset"); chk("mid_reset_pc", pc, 200); chk("mid_reset_done", done, 0);
        rst = 1'b0;
        step("post_reset_idle");

        // Out-of-range select uses base 0; RAS must be empty after reset
        start = 1'b1; sel = 2'd3; step("arm_sel3");
        start = 1'b0; step("run_sel3"); chk("sel3_pc", pc, 200);
        ctl(0,0,0,0,0,0,1,0); step("ret_after_reset");
        ctl(0,0,0,0,0,0,0,0); step("tail");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
